// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access path.
// Used by mem_access_unit and by the load alignment logic.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} memStateT;

   // Little-endian byte strobes; the reserved size behaves as a word.
   function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] addrLo);
      case (size)
         SZ_BYTE: gen_strobe = 4'b0001 << addrLo;
         SZ_HALF: gen_strobe = 4'b0011 << {addrLo[1], 1'b0};
         default: gen_strobe = 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addrLo);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = addrLo[0];
         default: misaligned = |addrLo;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a raw bus word and sign/zero extends it.
// Purely combinational so other load paths can reuse it.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rawWord,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        isSigned,
   output logic [31:0] result
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      case (offset)
         2'd0:    byteLane = rawWord[7:0];
         2'd1:    byteLane = rawWord[15:8];
         2'd2:    byteLane = rawWord[23:16];
         default: byteLane = rawWord[31:24];
      endcase
      halfLane = offset[1] ? rawWord[31:16] : rawWord[15:0];
   end

   always_comb begin
      case (size)
         SZ_BYTE: result = {{24{isSigned & byteLane[7]}}, byteLane};
         SZ_HALF: result = {{16{isSigned & halfLane[15]}}, halfLane};
         default: result = rawWord;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Turns a MEM-stage load/store into one strobed bus transaction, stalling the
// pipeline until it completes, and flags misalignment and bus timeouts.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        addr_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   memStateT   state;
   logic [CNT_W-1:0] count;
   logic [1:0] laneOff;
   logic [1:0] accSize;
   logic       accSigned;
   logic       isMisaligned;
   logic       timeoutHit;
   logic [31:0] wdataRep;
   logic [31:0] alignedData;

   assign isMisaligned = misaligned(req_size, req_addr[1:0]);
   assign addr_err     = req_valid & isMisaligned;
   assign timeoutHit   = (count == CNT_W'(TIMEOUT_CYCLES - 1));

   // Gated by reset so the pipeline is released the instant reset asserts.
   assign stall = rst & (((state == IDLE) & req_valid & ~isMisaligned) |
                         (state == REQ) | (state == WAIT));

   always_comb begin
      case (req_size)
         SZ_BYTE: wdataRep = {4{req_wdata[7:0]}};
         SZ_HALF: wdataRep = {2{req_wdata[15:0]}};
         default: wdataRep = req_wdata;
      endcase
   end

   load_align uAlign (
      .rawWord  (bus_rdata),
      .offset   (laneOff),
      .size     (accSize),
      .isSigned (accSigned),
      .result   (alignedData)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         laneOff   <= '0;
         accSize   <= '0;
         accSigned <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wstrb <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
         bus_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && !isMisaligned) begin
                  bus_req   <= 1'b1;
                  bus_we    <= req_we;
                  bus_addr  <= {req_addr[31:2], 2'b00};
                  bus_wstrb <= gen_strobe(req_size, req_addr[1:0]);
                  bus_wdata <= wdataRep;
                  laneOff   <= req_addr[1:0];
                  accSize   <= req_size;
                  accSigned <= req_signed;
                  count     <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               count <= count + CNT_W'(1);
               // A read granted together with its data skips WAIT entirely.
               if (bus_gnt && (bus_we || bus_rvalid)) begin
                  bus_req <= 1'b0;
                  if (!bus_we) rdata <= alignedData;
                  state <= DONE;
               end else if (timeoutHit) begin
                  bus_req <= 1'b0;
                  rdata   <= '0;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else if (bus_gnt) begin
                  bus_req <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               count <= count + CNT_W'(1);
               if (bus_rvalid) begin
                  rdata <= alignedData;
                  state <= DONE;
               end else if (timeoutHit) begin
                  rdata   <= '0;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               bus_err <= 1'b0;
               count   <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalignment, timeout,
// asynchronous reset and back-to-back accesses.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rdata;
   logic        stall, addr_err, bus_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;
   int episodes = 0;
   int epStart;
   logic prevReq = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rdata      (rdata),
      .stall      (stall),
      .addr_err   (addr_err),
      .bus_err    (bus_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wstrb  (bus_wstrb),
      .bus_wdata  (bus_wdata),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   // Rising edges of bus_req, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus_req && !prevReq) episodes = episodes + 1;
      prevReq = bus_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic setReq(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst bus_req", bus_req, 1'b0);
      chk("rst stall", stall, 1'b0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst bus_err", bus_err, 1'b0);
      chk("rst bus_addr", bus_addr, 32'h0);
      chk("rst wstrb", bus_wstrb, 4'h0);
      chk("rst wdata", bus_wdata, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // 1: store byte, grant in first REQ cycle
      setReq(1'b1, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00A5);
      #1 chk("t1 stall idle", stall, 1'b1);
      chk("t1 addr_err", addr_err, 1'b0);
      @(negedge clk);
      chk("t1 bus_req", bus_req, 1'b1);
      chk("t1 bus_we", bus_we, 1'b1);
      chk("t1 bus_addr", bus_addr, 32'h0000_1000);
      chk("t1 wstrb", bus_wstrb, 4'b1000);
      chk("t1 wdata", bus_wdata, 32'hA5A5_A5A5);
      chk("t1 stall req", stall, 1'b1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("t1 stall done", stall, 1'b0);
      chk("t1 bus_req done", bus_req, 1'b0);
      chk("t1 bus_err", bus_err, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("t1 idle bus_req", bus_req, 1'b0);

      // 2: signed byte load, rvalid three cycles after grant
      setReq(1'b0, SZ_BYTE, 1'b1, 32'h0000_2001, 32'h0);
      @(negedge clk);
      chk("t2 bus_req", bus_req, 1'b1);
      chk("t2 bus_we", bus_we, 1'b0);
      chk("t2 bus_addr", bus_addr, 32'h0000_2000);
      chk("t2 wstrb", bus_wstrb, 4'b0010);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("t2 bus_req wait", bus_req, 1'b0);
      chk("t2 stall w1", stall, 1'b1);
      @(negedge clk);
      chk("t2 stall w2", stall, 1'b1);
      @(negedge clk);
      chk("t2 stall w3", stall, 1'b1);
      bus_rvalid = 1'b1; bus_rdata = 32'h1234_80FF;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_BEEF;
      chk("t2 rdata signed", rdata, 32'hFFFF_FF80);
      chk("t2 stall done", stall, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("t2 rdata hold", rdata, 32'hFFFF_FF80);

      // 2b: same load unsigned
      setReq(1'b0, SZ_BYTE, 1'b0, 32'h0000_2001, 32'h0);
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_80FF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("t2 rdata unsigned", rdata, 32'h0000_0080);
      req_valid = 1'b0;
      @(negedge clk);

      // 3: signed half load at upper half, then misaligned requests
      setReq(1'b0, SZ_HALF, 1'b1, 32'h0000_2002, 32'h0);
      @(negedge clk);
      chk("t3 wstrb", bus_wstrb, 4'b1100);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h8001_0000;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("t3 rdata half", rdata, 32'hFFFF_8001);
      req_valid = 1'b0;
      @(negedge clk);
      setReq(1'b0, SZ_WORD, 1'b0, 32'h0000_2006, 32'h0);
      #1 chk("t3 addr_err", addr_err, 1'b1);
      chk("t3 stall mis", stall, 1'b0);
      @(negedge clk);
      chk("t3 bus_req mis", bus_req, 1'b0);
      chk("t3 stall mis2", stall, 1'b0);
      @(negedge clk);
      chk("t3 bus_req mis3", bus_req, 1'b0);
      setReq(1'b1, SZ_HALF, 1'b0, 32'h0000_2001, 32'h0);
      #1 chk("t3 half addr_err", addr_err, 1'b1);
      req_valid = 1'b0;
      #1 chk("t3 addr_err clr", addr_err, 1'b0);
      @(negedge clk);

      // 4: timeout after 8 REQ cycles, then a normal load
      setReq(1'b1, SZ_WORD, 1'b0, 32'h0000_4000, 32'h1122_3344);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("t4 bus_req c%0d", i), bus_req, 1'b1);
      end
      @(negedge clk);
      chk("t4 bus_req drop", bus_req, 1'b0);
      chk("t4 bus_err", bus_err, 1'b1);
      chk("t4 rdata zero", rdata, 32'h0);
      chk("t4 stall done", stall, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("t4 bus_err clr", bus_err, 1'b0);
      setReq(1'b0, SZ_HALF, 1'b0, 32'h0000_4006, 32'h0);
      @(negedge clk);
      chk("t4 next bus_req", bus_req, 1'b1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBEEF_1234;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("t4 next rdata", rdata, 32'h0000_BEEF);
      chk("t4 next bus_err", bus_err, 1'b0);
      req_valid = 1'b0;
      @(negedge clk);

      // 5: asynchronous reset in WAIT
      setReq(1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0);
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("t5 stall wait", stall, 1'b1);
      chk("t5 rdata pre", rdata, 32'h0000_BEEF);
      #2 rst = 1'b0;
      #1 chk("t5 rst bus_req", bus_req, 1'b0);
      chk("t5 rst stall", stall, 1'b0);
      chk("t5 rst rdata", rdata, 32'h0);
      chk("t5 rst bus_addr", bus_addr, 32'h0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("t5 post bus_req", bus_req, 1'b0);
      setReq(1'b0, SZ_WORD, 1'b0, 32'h0000_3000, 32'h0);
      @(negedge clk);
      chk("t5 bus_addr", bus_addr, 32'h0000_3000);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_1234;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("t5 rdata word", rdata, 32'h5A5A_1234);
      req_valid = 1'b0;
      @(negedge clk);

      // 6: back-to-back store then load with grant and data together
      epStart = episodes;
      setReq(1'b1, SZ_BYTE, 1'b0, 32'h0000_5000, 32'h0000_007F);
      @(negedge clk);
      chk("t6 st wdata", bus_wdata, 32'h7F7F_7F7F);
      chk("t6 st wstrb", bus_wstrb, 4'b0001);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("t6 st done stall", stall, 1'b0);
      setReq(1'b0, SZ_WORD, 1'b0, 32'h0000_5004, 32'h0);
      @(negedge clk);
      chk("t6 ld idle stall", stall, 1'b1);
      chk("t6 ld idle bus_req", bus_req, 1'b0);
      @(negedge clk);
      chk("t6 ld bus_addr", bus_addr, 32'h0000_5004);
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h89AB_CDEF;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      chk("t6 ld no wait", stall, 1'b0);
      chk("t6 ld rdata", rdata, 32'h89AB_CDEF);
      chk("t6 ld bus_req", bus_req, 1'b0);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6 episodes", episodes - epStart, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the MEM pipeline stage and the data-memory bus; replaces the zero-latency ReadDataM path.
- Converts one load/store per instruction into a single bus transaction with byte strobes.
- Aligns and extends read data, and stalls the pipeline while the bus transaction is outstanding.
- Flags misaligned addresses and bus timeouts so later exception logic can consume them.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted (1..65535)
CNT_W, 16, width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  MEM stage holds a load or store; held stable while stall=1
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address (ALUOutM)
req_wdata  input  32  store data, right-justified (WriteDataM)
rdata  output  32  aligned, extended load result, valid in DONE
stall  output  1  freeze pipeline (StallF/StallD/E/M)
addr_err  output  1  combinational misalignment flag, no bus access issued
bus_err  output  1  one-cycle pulse in DONE when the access timed out
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  32  word address, {req_addr[31:2],2'b00}
bus_wstrb  output  4  byte strobes
bus_wdata  output  32  lane-replicated store data
bus_gnt  input  1  bus accepted request (write complete / read launched)
bus_rvalid  input  1  read data valid
bus_rdata  input  32  raw read word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. All registered outputs go to 0 immediately: bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, rdata, bus_err. Reset mid-transaction drops bus_req in the same instant and discards the access.
- Misalignment: half with addr[0]=1, or word/reserved with addr[1:0]!=0.
  - addr_err=req_valid&misaligned in every state (combinational).
  - A misaligned request never leaves IDLE, and stall stays 0.
- Strobes (little-endian):
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Write data: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
- Stall equation: stall=(state==IDLE & req_valid & ~misaligned) | state==REQ | state==WAIT.
  - stall=0 in DONE, which lets the instruction advance on that edge.
- FSM:
  - IDLE: on req_valid & ~misaligned, register bus_addr/wstrb/wdata/we, the lane offset, size and sign; set bus_req=1; go to REQ. Otherwise stay.
  - REQ: bus_req=1 and counter increments. On bus_gnt, clear bus_req; a write goes to DONE, a read goes to WAIT. bus_gnt and bus_rvalid in the same cycle for a read: capture data, go to DONE.
  - WAIT: bus_req=0 and counter increments. On bus_rvalid, capture the extracted data into rdata and go to DONE. bus_rvalid outside WAIT/REQ is ignored.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 in REQ or WAIT without completion, clear bus_req, set rdata=0, set bus_err, go to DONE. Completion and timeout in the same cycle: completion wins, bus_err=0.
  - DONE: exactly one cycle. rdata holds its value until the next capture. bus_err is cleared on exit. Counter is cleared. Go to IDLE.
- Latency:
  - Store with gnt in the first REQ cycle: stall for 2 cycles (IDLE, REQ), DONE on the 3rd.
  - Load with gnt and rvalid 1 cycle apart: IDLE, REQ, WAIT stalled, then DONE.
- Read extraction: byte=lane addr[1:0], half=lane addr[1]. Extend to 32 bits per req_signed. Word passes through unchanged.
- Back-to-back requests: the request seen in IDLE after DONE is always the next instruction, so no duplicate issue occurs.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, REQ, WAIT, DONE)
  - function gen_strobe(size, addr_lo)
  - function misaligned(size, addr_lo)
- One combinational sub-module, load_align(raw word, offset, size, signed -> 32-bit result). It is reused later by the uncached/IO path.

Test Plan:
1. Store byte: addr=0x1003, wdata=0x000000A5, gnt on the 1st REQ cycle -> bus_addr=0x1000, wstrb=4'b1000, bus_wdata=0xA5A5A5A5; stall high 2 cycles, DONE on the 3rd.
2. Signed byte load: addr=0x2001, bus_rdata=0x1234_80FF, rvalid 3 cycles after gnt -> rdata=0xFFFFFF80. Repeat unsigned -> 0x00000080; stall held through all of WAIT.
3. Half load at addr=0x2002, rdata=0x8001_0000, signed -> 0xFFFF8001. Word load at addr=0x2006 -> addr_err=1, bus_req never asserted, stall=0.
4. Timeout: TIMEOUT_CYCLES=8, gnt never asserted -> bus_req drops after 8 REQ cycles, DONE with bus_err=1 and rdata=0. Next request is serviced normally.
5. Reset mid-WAIT: rst low asynchronously between edges -> bus_req/stall/rdata=0 immediately, state IDLE. After release, a word load at 0x3000 completes with rdata=bus_rdata.
6. Back-to-back store then load, gnt+rvalid in the same cycle for the load -> exactly two bus_req episodes, load goes REQ->DONE with no WAIT, correct rdata.
